// File: rtl/ms_stopwatch_pkg.sv
// rtl/ms_stopwatch_pkg.sv - shared state type and BCD constants for ms_stopwatch
package ms_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         DIGITS  = 4;

endpackage

// File: rtl/ms_stopwatch_bcd_counter4.sv
// rtl/ms_stopwatch_bcd_counter4.sv - 4-digit BCD incrementer with wrap/saturate
module bcd_counter4
    import ms_stopwatch_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  sat,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  wrap
);

    logic [4*DIGITS-1:0] bcd_next;
    logic                carry;

    // Ripple the increment upward; a digit at (or above) 9 rolls to 0 and passes the carry on.
    always_comb begin
        bcd_next = bcd;
        carry    = inc;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] >= BCD_MAX) begin
                    bcd_next[4*i +: 4] = 4'd0;
                end else begin
                    bcd_next[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clr) begin
            bcd <= '0;
        end else if (inc && !(wrap && sat)) begin
            bcd <= bcd_next;
        end
    end

endmodule

// File: rtl/ms_stopwatch.sv
// rtl/ms_stopwatch.sv - millisecond stopwatch top; MS_STOPWATCH_SATURATE_EN selects saturate at 9999
module ms_stopwatch
    import ms_stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ms_clk,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [15:0] bcd,
    output logic        running,
    output logic        done,
    output logic        overflow
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   tick_q;
    logic                   sync_bit;

    sw_state_t state_q;
    sw_state_t state_n;

    logic inc;
    logic sat;
    logic wrap;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // valid_q tracks when the chain holds real samples; armed_q then waits for a low level,
    // so an ms_clk already high at reset release cannot be mistaken for a rising edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q  <= '0;
            valid_q <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ms_clk};
            valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_bit;
            if (valid_q[SYNC_STAGES-1] && !sync_bit) begin
                armed_q <= 1'b1;
            end
            tick_q  <= sync_bit & ~prev_q & armed_q;
        end
    end

    always_comb begin
        state_n = state_q;
        if (clear) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start && !stop) state_n = RUN;
                RUN:     if (stop) state_n = HOLD;
                HOLD:    if (start && !stop) state_n = RUN;
                default: state_n = IDLE;
            endcase
        end
    end

    // A tick is dropped when the same cycle leaves RUN.
    assign inc = tick_q && (state_q == RUN) && !clear && !stop;

`ifdef MS_STOPWATCH_SATURATE_EN
    assign sat = 1'b1;
`else
    assign sat = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            running  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_n;
            running  <= (state_n == RUN);
            done     <= (state_q == RUN) && (state_n == HOLD);
            overflow <= clear ? 1'b0 : (overflow | (inc & wrap));
        end
    end

    bcd_counter4 u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (inc),
        .sat     (sat),
        .bcd     (bcd),
        .wrap    (wrap)
    );

endmodule

// File: doc/ms_stopwatch.md
MS_STOPWATCH -- requirements
Module: ms_stopwatch

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on ms_clk (legal 2..3).
REQ-002 clock  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 ms_clk  input  1  divided clock from the millisecond divider; treated as data, never used as a clock.
REQ-005 start  input  1  level-sampled command; begin or resume counting.
REQ-006 stop  input  1  level-sampled command; freeze count.
REQ-007 clear  input  1  level-sampled command; zero count and return to idle.
REQ-008 bcd  output  16  count as 4 BCD digits, [15:12]=thousands .. [3:0]=units, registered.
REQ-009 running  output  1  high while in RUN state, registered.
REQ-010 done  output  1  one-cycle pulse on every RUN->HOLD transition.
REQ-011 overflow  output  1  sticky flag, count passed 9999.

Function
REQ-012 ms_clk SHALL pass through SYNC_STAGES flops; a tick is one cycle high when the synchronized value is 1 and its previous value was 0.
REQ-013 Each ms_clk rising edge SHALL produce exactly one tick; a falling edge SHALL produce none.
REQ-014 States are IDLE, RUN, HOLD.
REQ-015 IDLE: start -> RUN; stop ignored.
REQ-016 RUN: stop -> HOLD with done=1 for that one cycle; start ignored.
REQ-017 HOLD: start -> RUN without clearing the count; stop ignored.
REQ-018 Priority each cycle: clear > stop > start.
REQ-019 clear in any state -> IDLE, bcd=0x0000, overflow=0, running=0, next cycle.
REQ-020 start and stop asserted together in RUN -> HOLD; in IDLE or HOLD -> state unchanged.
REQ-021 In RUN, a tick SHALL increment bcd by 1 decimal with carry across digits; bcd updates the cycle after the tick.
REQ-022 A tick in the same cycle stop or clear is taken SHALL NOT be counted; a tick in the same cycle start is taken SHALL NOT be counted.
REQ-023 Ticks outside RUN SHALL be discarded, not queued.
REQ-024 Each BCD digit SHALL never hold a value above 9.
REQ-025 Tick-to-bcd latency is SYNC_STAGES+2 clock cycles from the ms_clk rising edge at the input pin.

Reset
REQ-026 While reset_n=0 at a clock edge: state=IDLE, bcd=0x0000, running=0, done=0, overflow=0, all synchronizer and edge flops=0.
REQ-027 Reset asserted mid-RUN SHALL abort without a done pulse.
REQ-028 Following reset release, an ms_clk already high SHALL NOT produce a tick until it falls and rises again.

Configuration
REQ-029 Macro MS_STOPWATCH_SATURATE_EN defined: a tick at 9999 leaves bcd=9999, sets overflow, and counting continues to be ignored until clear.
REQ-030 Macro undefined: a tick at 9999 wraps bcd to 0000, sets overflow (sticky), and counting continues.

Structure
REQ-031 Shared package ms_stopwatch_pkg holds the state enum (IDLE, RUN, HOLD), BCD_MAX digit constant 4'd9, and DIGITS=4.
REQ-032 One sub-module, bcd_counter4, SHALL hold the 4-digit increment/carry logic with inputs clock, reset_n, clr, inc, sat, and outputs bcd, wrap.

Verification
REQ-033 Reset, start, 25 ms_clk periods, stop -> bcd=0x0025, done high exactly 1 cycle, running=0.
REQ-034 HOLD at 0x0025, 10 ms_clk periods, start, 5 periods, stop -> bcd=0x0030.
REQ-035 Preload 0x0999 via ticks, 1 tick -> 0x1000, all digits ≤9 throughout.
REQ-036 At 9999, 1 tick -> with macro bcd=0x9999, overflow=1; without macro bcd=0x0000, overflow=1.
REQ-037 clear, stop, start all high in RUN -> next cycle IDLE, bcd=0x0000, done=0.
REQ-038 Tick coincident with stop at 0x0007 -> bcd stays 0x0007; reset_n low mid-RUN -> all outputs 0, no done.
